// File: rtl/router_pkg.sv
// Shared definitions for the serial frame router.
//   router_state_t : frame controller states
//   HDR_LEN        : header bits captured by the shift register per frame
//   NPORTS         : number of payload output ports
//   payload_last() : true on the final PAYLOAD cycle of a frame
package router_pkg;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} router_state_t;

  localparam int HDR_LEN = 6;
  localparam int NPORTS  = 4;

  // A zero-length frame still spends one cycle in PAYLOAD, so it ends at once.
  // Otherwise the last bit is the one where the count reaches len-1, which
  // keeps the 4-bit count at or below 14 for the largest (15-bit) payload.
  function automatic logic payload_last(input logic [3:0] pcnt,
                                        input logic [3:0] len);
    return (len == 4'd0) || (pcnt == len - 4'd1);
  endfunction

endpackage

// File: rtl/serial_frame_router_frame_counter.sv
// Wrapping frame counter.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset, clears the count
//   inc   : add one on this edge
//   count : current count, wraps from all-ones back to zero
module frame_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_router.sv
// Frame controller and payload router behind the 8-bit header shift register.
// Detects a start bit on the serial line, enables the register for the header
// shift, steers the following payload bits to the addressed port, and clears
// the register at end of frame.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset; aborts any frame in progress
//   serIn  : serial line (idles high), shared with the shift register
//   n      : payload length, shift register bits [3:0]
//   d      : destination port, shift register bits [5:4]
//   shen   : shift enable to the register (header cycles only)
//   init   : synchronous clear to the register (end of frame)
//   valid  : a payload bit is being routed this cycle
//   out    : out[d] = serIn while valid, all other bits zero
//   done   : one-cycle end-of-frame pulse
//   frames : completed-frame count, wraps 255 -> 0
module serial_frame_router #(
  parameter int HDR_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serIn,
  input  logic [3:0] n,
  input  logic [1:0] d,
  output logic       shen,
  output logic       init,
  output logic       valid,
  output logic [3:0] out,
  output logic       done,
  output logic [7:0] frames
);

  import router_pkg::*;

  localparam logic [2:0] HCNT_LAST = 3'(HDR_LEN - 1);

  router_state_t state;
  logic [2:0]    hcnt;
  logic [3:0]    pcnt;
  logic          in_payload;
  logic [NPORTS-1:0] demux;

  // Control FSM. shen/init/done/in_payload are registered alongside the state
  // so each output is a clean decode of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      pcnt       <= '0;
      shen       <= 1'b0;
      init       <= 1'b0;
      done       <= 1'b0;
      in_payload <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Start bit: consumed here, never shifted into the register.
          if (!serIn) begin
            state <= HDR;
            hcnt  <= '0;
            shen  <= 1'b1;
          end
        end

        HDR: begin
          if (hcnt == HCNT_LAST) begin
            state      <= PAYLOAD;
            hcnt       <= '0;
            pcnt       <= '0;
            shen       <= 1'b0;
            in_payload <= 1'b1;
          end else begin
            hcnt <= hcnt + 3'd1;
          end
        end

        PAYLOAD: begin
          // n and d are frozen in the register while shen is low.
          if (payload_last(pcnt, n)) begin
            state      <= DONE;
            in_payload <= 1'b0;
            done       <= 1'b1;
            init       <= 1'b1;
          end else begin
            pcnt <= pcnt + 4'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          init  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          shen       <= 1'b0;
          init       <= 1'b0;
          done       <= 1'b0;
          in_payload <= 1'b0;
        end
      endcase
    end
  end

  // A zero-length frame still has a PAYLOAD cycle, but nothing is routed.
  assign valid = in_payload && (n != 4'd0);

  // Same-cycle pass-through of the serial line to the addressed port.
  always_comb begin
    demux = '0;
    if (valid) begin
      demux[d] = serIn;
    end
  end

  assign out = demux;

  // Counts on the edge leaving DONE; aborted frames never reach DONE.
  frame_counter #(
    .W(8)
  ) u_frame_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (state == DONE),
    .count(frames)
  );

endmodule

// File: tb/tb_serial_frame_router.sv
// Bench for serial_frame_router with a behavioural model of the header shift
// register. Stimulus pushes the expected shen/valid/done events (cycle number
// and value) into a queue; a monitor pops and compares them as the DUT shows them.
module tb_serial_frame_router;

  localparam int K_SHEN  = 1;
  localparam int K_VALID = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] val;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       serIn;
  logic [3:0] n;
  logic [1:0] d;
  logic       shen;
  logic       init;
  logic       valid;
  logic [3:0] out;
  logic       done;
  logic [7:0] frames;

  logic [7:0] sreg;
  logic       sreg_rst;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   frames_exp = 0;
  ev_t  q[$];
  ev_t  mon_e;
  int   mon_kind;

  serial_frame_router #(.HDR_LEN(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .serIn (serIn),
    .n     (n),
    .d     (d),
    .shen  (shen),
    .init  (init),
    .valid (valid),
    .out   (out),
    .done  (done),
    .frames(frames)
  );

  // Header shift register model: active-high reset via inverter, MSB-first shift.
  assign sreg_rst = ~rst;
  always @(posedge clk or posedge sreg_rst) begin
    if (sreg_rst)  sreg <= 8'd0;
    else if (init) sreg <= 8'd0;
    else if (shen) sreg <= {sreg[6:0], serIn};
  end
  assign n = sreg[3:0];
  assign d = sreg[5:4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int c, input logic [7:0] v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    q.push_back(e);
  endtask

  // Hold serIn for the current cycle, then advance to just after the next edge.
  task automatic drive(input logic b);
    serIn = b;
    @(posedge clk);
    #1;
  endtask

  // Expected behaviour of one frame whose start bit is in cycle k.
  task automatic expect_frame(input int k, input logic [1:0] fd, input logic [3:0] fn,
                              input logic [14:0] pay);
    for (int i = 1; i <= 6; i++) push(K_SHEN, k + i, 8'd0);
    for (int i = 0; i < int'(fn); i++) push(K_VALID, k + 7 + i, 8'(4'(pay[i]) << fd));
    push(K_DONE, (fn == 4'd0) ? k + 8 : k + 7 + int'(fn), 8'(frames_exp));
    frames_exp = (frames_exp + 1) % 256;
  endtask

  task automatic send_frame(input logic [1:0] fd, input logic [3:0] fn,
                            input logic [14:0] pay, input int gap);
    logic [5:0] hdr;
    hdr = {fd, fn};
    for (int i = 0; i < gap; i++) drive(1'b1);
    expect_frame(cyc, fd, fn, pay);
    drive(1'b0);
    for (int i = 5; i >= 0; i--) drive(hdr[i]);
    for (int i = 0; i < int'(fn); i++) drive(pay[i]);
    if (fn == 4'd0) drive(1'($urandom));
    drive(1'($urandom));  // DONE cycle: line is ignored
  endtask

  // Monitor: invariants every cycle, then ordered event matching.
  always @(negedge clk) begin
    if (rst) begin
      check("shen_init_exclusive", int'(shen & init), 0);
      check("init_matches_done", int'(init), int'(done));
      if (!valid) check("out_zero_when_idle", int'(out), 0);
      if (shen || valid || done) begin
        mon_kind = done ? K_DONE : (valid ? K_VALID : K_SHEN);
        if (q.size() == 0) begin
          check("unexpected_event_kind", mon_kind, 0);
        end else begin
          mon_e = q.pop_front();
          check("event_kind", mon_kind, mon_e.kind);
          check("event_cycle", cyc, mon_e.cyc);
          if (valid) check("out_value", int'(out), int'(mon_e.val));
          if (done)  check("frames_at_done", int'(frames), int'(mon_e.val));
        end
      end
    end
  end

  initial begin
    logic [14:0] pay;
    logic [5:0]  hdr;
    rst   = 1'b0;
    serIn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_shen", int'(shen), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_done", int'(done), 0);
    check("reset_init", int'(init), 0);
    check("reset_out", int'(out), 0);
    check("reset_frames", int'(frames), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle line.
    for (int i = 0; i < 20; i++) drive(1'b1);
    check("idle_frames", int'(frames), 0);

    // Directed frames.
    send_frame(2'd2, 4'd3, 15'b101, 2);
    check("frames_after_first", int'(frames), 1);
    send_frame(2'd1, 4'd0, 15'h7fff, 3);
    send_frame(2'd3, 4'd15, 15'b101010101010101, 1);
    send_frame(2'd0, 4'd5, 15'b10011, 0);
    send_frame(2'd1, 4'd2, 15'b11, 0);
    check("frames_after_back_to_back", int'(frames), 5);

    // Reset during the 3rd payload bit of a 10-bit frame.
    pay = 15'b1111111111;
    hdr = {2'd2, 4'd10};
    drive(1'b1);
    expect_frame(cyc, 2'd2, 4'd10, pay);
    drive(1'b0);
    for (int i = 5; i >= 0; i--) drive(hdr[i]);
    drive(pay[0]);
    drive(pay[1]);
    serIn = pay[2];
    #1;
    rst = 1'b0;
    q.delete();
    frames_exp = 0;
    #1;
    check("abort_valid", int'(valid), 0);
    check("abort_out", int'(out), 0);
    check("abort_done", int'(done), 0);
    check("abort_shen", int'(shen), 0);
    check("abort_frames", int'(frames), 0);
    serIn = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    // Start bit sampled on the first edge with reset released.
    send_frame(2'd1, 4'd4, 15'b0110, 0);
    check("frames_after_abort", int'(frames), 1);

    // Randomized frames, enough to wrap the frame counter.
    for (int f = 0; f < 262; f++) begin
      send_frame(2'($urandom), 4'($urandom), 15'($urandom), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 6; i++) drive(1'b1);
    check("queue_drained", q.size(), 0);
    check("final_frames", int'(frames), frames_exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_frame_router.md
# serial_frame_router

Controller and payload router sitting directly downstream of the 8-bit header shift register. It detects a frame start on the serial line and drives `shen` so the register captures a 6-bit header, holding a 2-bit destination `d` and a 4-bit length `n`. It then steers the next `n` serial bits to output port `d`, and finally pulses `init` to clear the register for the next frame. One instance per serial input.

## Interface
Parameters:
- `HDR_LEN`, 6: header bits shifted into the register per frame; fixed at 6 for the current register.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset; named as in the rest of the codebase, polarity low.
- `serIn`  in  1  serial line, shared with the shift register; idles high.
- `n`  in  4  payload length from shift register bits [3:0].
- `d`  in  2  destination from shift register bits [5:4].
- `shen`  out  1  shift enable to the shift register.
- `init`  out  1  synchronous clear to the shift register.
- `valid`  out  1  high while a payload bit is being routed.
- `out`  out  4  routed data: `out[d] = serIn` when `valid`, all other bits 0.
- `done`  out  1  one-cycle end-of-frame pulse.
- `frames`  out  8  count of completed frames; wraps 255 -> 0.

## Operation
- States: IDLE, HDR, PAYLOAD, DONE.
- IDLE:
  - All outputs 0.
  - `serIn == 0` sampled on a clock edge -> HDR. This is the start bit; it is not shifted.
  - `serIn == 1` -> stay in IDLE.
- HDR:
  - `shen = 1` for exactly `HDR_LEN` cycles, tracked by a 3-bit counter `hcnt`.
  - Bits arrive MSB-first: `d[1], d[0], n[3], n[2], n[1], n[0]`.
  - On the edge ending the 6th cycle -> PAYLOAD; `pcnt` is cleared.
- PAYLOAD:
  - `shen = 0`, so `n` and `d` stay stable and are used directly; no extra latching.
  - `valid = (n != 0)`; `out[d] = serIn & valid`.
  - `pcnt` increments each cycle.
  - Exits to DONE when `n == 0` or `pcnt == n - 1`.
  - With `n == 0`, one idle cycle is spent with `valid = 0`.
- DONE:
  - `done = 1` and `init = 1` for one cycle.
  - `frames` increments on the edge leaving DONE.
  - Always -> IDLE.
  - The shift register is zeroed on the same edge.
- `serIn` is ignored in DONE. A start bit may be detected in the first IDLE cycle after DONE, giving back-to-back frames with no gap.
- Reset (`rst == 0`, any time, including mid-frame):
  - State IDLE; `hcnt`, `pcnt`, `frames` = 0.
  - All outputs 0 immediately; any partial frame is discarded.
  - The shift register is reset by its own `rst`. No `done` is produced for an aborted frame.
- Width rules:
  - `pcnt` is 4-bit and never exceeds 14, since the exit is taken at `n - 1`.
  - The maximum payload is 15 bits.

## Timing
- All outputs are Moore-decoded from state, except `out`, which is combinational from `serIn`, `d` and `valid` (same-cycle pass-through, zero latency).
- Start bit sampled at cycle k:
  - HDR occupies cycles k+1..k+6.
  - Payload bits occupy k+7..k+6+n.
  - DONE is at k+7+n for n ≥ 1, and at k+8 for n = 0.
- Frame length is 8+n cycles including the start bit (9 cycles for n = 0).
- `shen` and `init` are never high in the same cycle.
- Reset release: the first start-bit sample is taken on the first rising edge with `rst == 1`.

## Structure
- Shared package `router_pkg`:
  - `typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} router_state_t`
  - `localparam int HDR_LEN = 6`
  - `localparam int NPORTS = 4`
- One natural sub-module: `frame_counter`, an 8-bit wrapping counter with increment enable and asynchronous active-low reset, used for `frames`.
- The FSM, `hcnt`, `pcnt` and the output demux live in the top module.
- The integration bench instantiates this block together with the shift register (`shen`, `init`, `n`, `d`, `serIn` and `clk` wired through). Its reset is adapted to the register's active-high `rst` with an inverter.

## Test plan
- Idle line: `serIn = 1` for 20 cycles -> `shen`, `valid`, `done` stay 0; `out = 0`; `frames = 0`.
- Frame start 0, header 1,0,0,0,1,1 (d=2, n=3), payload 1,0,1:
  - `shen` high at k+1..k+6.
  - `valid` at k+7..k+9, with `out` = 4'b0100, 4'b0000, 4'b0100.
  - `done` and `init` at k+10; `frames = 1`.
- n=0, d=1 -> no `valid` and `out` stays 0; `done` at k+8.
- n=15, d=3, alternating payload -> 15 `valid` cycles on `out[3]` only; `pcnt` peaks at 14; `done` at k+22.
- Two frames back-to-back (second start bit in the cycle after DONE) -> both routed correctly; `frames = 2`.
- `rst` low during the 3rd payload bit of a 10-bit frame -> outputs 0 immediately, no `done`, `frames` = 0. After release, a new frame routes correctly.
